// File: rtl/apb3_pkg.sv
// Shared APB3 definitions: bus widths, the completer FSM state type and
// the byte-address to word-index helper.
package apb3_pkg;

    localparam int APB3_DATA_W = 32;
    localparam int APB3_ADDR_W = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        READY = 2'd2
    } apb3_slv_state_t;

    // Full word index of a byte address; callers slice it to their depth.
    function automatic logic [APB3_ADDR_W-3:0] apb3_word_idx(input logic [APB3_ADDR_W-1:0] addr);
        return addr[APB3_ADDR_W-1:2];
    endfunction

endpackage

// File: rtl/apb3_regfile.sv
// DEPTH x 32 register storage: one synchronous write port, one
// asynchronous read port, asynchronous clear on PRESETn.
module apb3_regfile
    import apb3_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic                   PCLK,
    input  logic                   PRESETn,
    input  logic                   we,
    input  logic [IDX_W-1:0]       waddr,
    input  logic [APB3_DATA_W-1:0] wdata,
    input  logic [IDX_W-1:0]       raddr,
    output logic [APB3_DATA_W-1:0] rdata
);

    logic [APB3_DATA_W-1:0] mem_reg [DEPTH];

    // Storage update: clear everything on reset, otherwise one word per write.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_reg[i] <= '0;
            end
        end else if (we) begin
            mem_reg[waddr] <= wdata;
        end
    end

    assign rdata = mem_reg[raddr];

endmodule

// File: rtl/apb3_slave_regbank.sv
// APB3 completer with a word-addressed register bank and WAIT_STATES
// access cycles of PREADY low before each completion.
// Optional feature macro: APB3_SLV_ERR_EN -- when defined, misaligned or
// out-of-range addresses complete with PSLVERR=1, no write and PRDATA=0;
// when undefined, the index simply wraps modulo DEPTH.
module apb3_slave_regbank
    import apb3_pkg::*;
#(
    parameter int DEPTH       = 16,
    parameter int WAIT_STATES = 1
) (
    input  logic                   PCLK,
    input  logic                   PRESETn,
    input  logic                   PSELx,
    input  logic                   PENABLE,
    input  logic                   PWRITE,
    input  logic [APB3_ADDR_W-1:0] PADDR,
    input  logic [APB3_DATA_W-1:0] PWDATA,
    output logic [APB3_DATA_W-1:0] PRDATA,
    output logic                   PREADY,
    output logic                   PSLVERR
);

    localparam int         IDX_W     = $clog2(DEPTH);
    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_STATES);
`ifdef APB3_SLV_ERR_EN
    localparam bit ERR_EN = 1'b1;
`else
    localparam bit ERR_EN = 1'b0;
`endif

    apb3_slv_state_t        state_reg, state_next;
    logic [3:0]             cnt_reg;
    logic [IDX_W-1:0]       idx_reg;
    logic                   err_reg;
    logic                   write_reg;
    logic [APB3_DATA_W-1:0] wdata_reg;
    logic [APB3_DATA_W-1:0] prdata_reg;
    logic                   pready_reg;
    logic                   pslverr_reg;

    logic [APB3_ADDR_W-3:0] word_idx;
    logic                   addr_err;
    logic                   setup;
    logic [IDX_W-1:0]       cur_idx;
    logic                   cur_err;
    logic                   cur_write;
    logic                   reg_we;
    logic [APB3_DATA_W-1:0] rd_data;

    // Request decode; in IDLE the live bus is used so that a zero-wait
    // transfer can fetch read data on the same edge that captures it.
    always_comb begin
        word_idx  = apb3_word_idx(PADDR);
        addr_err  = ERR_EN && ((word_idx >= (APB3_ADDR_W-2)'(DEPTH)) || (PADDR[1:0] != 2'b00));
        setup     = PSELx && !PENABLE;
        cur_idx   = idx_reg;
        cur_err   = err_reg;
        cur_write = write_reg;
        if (state_reg == IDLE) begin
            cur_idx   = word_idx[IDX_W-1:0];
            cur_err   = addr_err;
            cur_write = PWRITE;
        end
    end

    // Next-state and register write strobe.
    always_comb begin
        state_next = state_reg;
        reg_we     = 1'b0;
        case (state_reg)
            IDLE: begin
                if (setup) begin
                    state_next = (WAIT_STATES > 0) ? WAIT : READY;
                end
            end
            WAIT: begin
                if (!PSELx) begin
                    state_next = IDLE;
                end else if (cnt_reg == 4'd1) begin
                    state_next = READY;
                end
            end
            READY: begin
                if (!PSELx) begin
                    state_next = IDLE;
                end else if (PENABLE) begin
                    reg_we     = write_reg && !err_reg;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Capture the request at setup and count down the wait states.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            cnt_reg   <= '0;
            idx_reg   <= '0;
            err_reg   <= 1'b0;
            write_reg <= 1'b0;
            wdata_reg <= '0;
        end else if (state_reg == IDLE && setup) begin
            cnt_reg   <= WAIT_LOAD;
            idx_reg   <= word_idx[IDX_W-1:0];
            err_reg   <= addr_err;
            write_reg <= PWRITE;
            wdata_reg <= PWDATA;
        end else if (state_reg == WAIT && cnt_reg != 4'd0) begin
            cnt_reg <= cnt_reg - 4'd1;
        end
    end

    // Registered response: valid in READY only, cleared on leaving it.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            pready_reg  <= 1'b0;
            pslverr_reg <= 1'b0;
            prdata_reg  <= '0;
        end else begin
            pready_reg  <= (state_next == READY);
            pslverr_reg <= (state_next == READY) && cur_err;
            if (state_next == READY && state_reg != READY) begin
                prdata_reg <= (cur_write || cur_err) ? '0 : rd_data;
            end else if (state_next != READY) begin
                prdata_reg <= '0;
            end
        end
    end

    apb3_regfile #(
        .DEPTH (DEPTH),
        .IDX_W (IDX_W)
    ) u_regfile (
        .PCLK    (PCLK),
        .PRESETn (PRESETn),
        .we      (reg_we),
        .waddr   (idx_reg),
        .wdata   (wdata_reg),
        .raddr   (cur_idx),
        .rdata   (rd_data)
    );

    assign PRDATA  = prdata_reg;
    assign PREADY  = pready_reg;
    assign PSLVERR = pslverr_reg;

endmodule

// File: tb/tb_apb3_slave_regbank.sv
// Directed bench for apb3_slave_regbank: three instances (0, 2 and 3 wait
// states) share the bus wires and are selected by their own PSELx.
`timescale 1ns/1ps
module tb_apb3_slave_regbank;

    logic        PCLK;
    logic        PRESETn;
    logic [2:0]  psel;
    logic        penable;
    logic        pwrite;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic [31:0] prdata [3];
    logic [2:0]  pready;
    logic [2:0]  pslverr;

    int total = 0;
    int bad   = 0;

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    apb3_slave_regbank #(.DEPTH(16), .WAIT_STATES(0)) u_w0 (
        .PCLK(PCLK), .PRESETn(PRESETn), .PSELx(psel[0]), .PENABLE(penable),
        .PWRITE(pwrite), .PADDR(paddr), .PWDATA(pwdata),
        .PRDATA(prdata[0]), .PREADY(pready[0]), .PSLVERR(pslverr[0]));

    apb3_slave_regbank #(.DEPTH(16), .WAIT_STATES(2)) u_w2 (
        .PCLK(PCLK), .PRESETn(PRESETn), .PSELx(psel[1]), .PENABLE(penable),
        .PWRITE(pwrite), .PADDR(paddr), .PWDATA(pwdata),
        .PRDATA(prdata[1]), .PREADY(pready[1]), .PSLVERR(pslverr[1]));

    apb3_slave_regbank #(.DEPTH(16), .WAIT_STATES(3)) u_w3 (
        .PCLK(PCLK), .PRESETn(PRESETn), .PSELx(psel[2]), .PENABLE(penable),
        .PWRITE(pwrite), .PADDR(paddr), .PWDATA(pwdata),
        .PRDATA(prdata[2]), .PREADY(pready[2]), .PSLVERR(pslverr[2]));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One APB transfer on instance u. Returns when PREADY is seen (during
    // AW); the following edge completes it, so a further call is back-to-back.
    // Address/data/direction are scrambled during the access phase.
    task automatic xfer(input int u, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wdata, output logic [31:0] rdata,
                        output logic err, output int cycles);
        logic seen;
        seen   = 1'b0;
        rdata  = '0;
        err    = 1'b0;
        @(posedge PCLK); #1;
        psel    = 3'b000;
        psel[u] = 1'b1;
        penable = 1'b0;
        pwrite  = wr;
        paddr   = addr;
        pwdata  = wdata;
        cycles  = 1;
        @(posedge PCLK); #1;
        penable = 1'b1;
        pwrite  = ~wr;
        paddr   = ~addr;
        pwdata  = ~wdata;
        cycles  = 2;
        for (int k = 0; k < 40; k++) begin
            if (pready[u]) begin
                seen  = 1'b1;
                rdata = prdata[u];
                err   = pslverr[u];
                break;
            end
            @(posedge PCLK); #1;
            cycles++;
        end
        check("ready_seen", {31'd0, seen}, 32'd1);
        $display("xfer u=%0d wr=%0d addr=%h wdata=%h rdata=%h err=%0d cycles=%0d",
                 u, wr, addr, wdata, rdata, err, cycles);
    endtask

    // Let the pending transfer complete, release the bus, check response cleared.
    task automatic bus_idle(input int u);
        @(posedge PCLK); #1;
        psel    = 3'b000;
        penable = 1'b0;
        check("idle_pready", {31'd0, pready[u]}, 32'd0);
        check("idle_prdata", prdata[u], 32'd0);
    endtask

    logic [31:0] rd;
    logic        er;
    int          cyc;

    initial begin
        PRESETn = 1'b0;
        psel    = 3'b000;
        penable = 1'b0;
        pwrite  = 1'b0;
        paddr   = '0;
        pwdata  = '0;
        repeat (3) @(posedge PCLK);
        #1;
        check("rst_pready", {29'd0, pready}, 32'd0);
        check("rst_pslverr", {29'd0, pslverr}, 32'd0);
        check("rst_prdata0", prdata[0], 32'd0);
        @(negedge PCLK);
        PRESETn = 1'b1;

        // Reset asserted while a read sits in READY (3 wait states).
        xfer(2, 1'b1, 32'h0, 32'h1111_1111, rd, er, cyc);
        check("w3_wr_cycles", cyc, 5);
        bus_idle(2);
        @(posedge PCLK); #1;
        psel[2] = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 32'h0;
        @(posedge PCLK); #1;
        penable = 1'b1;
        repeat (3) begin
            check("w3_wait_pready", {31'd0, pready[2]}, 32'd0);
            @(posedge PCLK); #1;
        end
        check("w3_ready", {31'd0, pready[2]}, 32'd1);
        check("w3_rd_before_rst", prdata[2], 32'h1111_1111);
        #2;
        PRESETn = 1'b0;
        #1;
        check("arst_pready", {31'd0, pready[2]}, 32'd0);
        check("arst_pslverr", {31'd0, pslverr[2]}, 32'd0);
        check("arst_prdata", prdata[2], 32'd0);
        psel = 3'b000; penable = 1'b0;
        repeat (2) @(posedge PCLK);
        @(negedge PCLK);
        PRESETn = 1'b1;
        xfer(2, 1'b0, 32'h0, 32'h0, rd, er, cyc);
        check("post_rst_rd0", rd, 32'h0);
        check("post_rst_cycles", cyc, 5);
        bus_idle(2);

        // Write then read with 2 wait states.
        xfer(1, 1'b1, 32'h08, 32'hDEAD_BEEF, rd, er, cyc);
        check("w2_wr_cycles", cyc, 4);
        check("w2_wr_err", {31'd0, er}, 32'd0);
        bus_idle(1);
        xfer(1, 1'b0, 32'h08, 32'h0, rd, er, cyc);
        check("w2_rd_cycles", cyc, 4);
        check("w2_rd_data", rd, 32'hDEAD_BEEF);
        check("w2_rd_err", {31'd0, er}, 32'd0);
        bus_idle(1);

        // Zero wait states, back-to-back transfers.
        xfer(0, 1'b1, 32'h0, 32'h0123_4567, rd, er, cyc);
        check("w0_wr0_cycles", cyc, 2);
        xfer(0, 1'b1, 32'h4, 32'h89AB_CDEF, rd, er, cyc);
        check("w0_wr4_cycles", cyc, 2);
        xfer(0, 1'b0, 32'h0, 32'h0, rd, er, cyc);
        check("w0_rd0_cycles", cyc, 2);
        check("w0_rd0_data", rd, 32'h0123_4567);
        xfer(0, 1'b0, 32'h4, 32'h0, rd, er, cyc);
        check("w0_rd4_cycles", cyc, 2);
        check("w0_rd4_data", rd, 32'h89AB_CDEF);
        bus_idle(0);

        // Abort: PSELx dropped in A1 of a write to 0x10 (3 wait states).
        xfer(2, 1'b1, 32'h10, 32'hCAFE_0010, rd, er, cyc);
        bus_idle(2);
        @(posedge PCLK); #1;
        psel[2] = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 32'h10; pwdata = 32'h0BAD_F00D;
        @(posedge PCLK); #1;
        penable = 1'b1;
        @(posedge PCLK); #1;
        psel = 3'b000; penable = 1'b0;
        repeat (4) begin
            @(posedge PCLK); #1;
            check("abort_pready", {31'd0, pready[2]}, 32'd0);
        end
        xfer(2, 1'b0, 32'h10, 32'h0, rd, er, cyc);
        check("abort_rd_data", rd, 32'hCAFE_0010);
        check("abort_rd_cycles", cyc, 5);
        bus_idle(2);

        // Out-of-range / misaligned addresses (2 wait states).
        xfer(1, 1'b1, 32'h0, 32'h5555_AAAA, rd, er, cyc);
        bus_idle(1);
`ifdef APB3_SLV_ERR_EN
        xfer(1, 1'b1, 32'h40, 32'h0000_1234, rd, er, cyc);
        check("err_wr_err", {31'd0, er}, 32'd1);
        check("err_wr_cycles", cyc, 4);
        bus_idle(1);
        xfer(1, 1'b0, 32'h02, 32'h0, rd, er, cyc);
        check("err_rd_err", {31'd0, er}, 32'd1);
        check("err_rd_data", rd, 32'h0);
        check("err_rd_cycles", cyc, 4);
        bus_idle(1);
        xfer(1, 1'b0, 32'h0, 32'h0, rd, er, cyc);
        check("err_reg0_kept", rd, 32'h5555_AAAA);
        check("err_reg0_err", {31'd0, er}, 32'd0);
        bus_idle(1);
`else
        xfer(1, 1'b1, 32'h40, 32'hA5A5_A5A5, rd, er, cyc);
        check("wrap_wr_err", {31'd0, er}, 32'd0);
        check("wrap_wr_cycles", cyc, 4);
        bus_idle(1);
        xfer(1, 1'b0, 32'h00, 32'h0, rd, er, cyc);
        check("wrap_rd_data", rd, 32'hA5A5_A5A5);
        check("wrap_rd_err", {31'd0, er}, 32'd0);
        bus_idle(1);
        xfer(1, 1'b0, 32'h02, 32'h0, rd, er, cyc);
        check("wrap_rd_unaligned", rd, 32'hA5A5_A5A5);
        bus_idle(1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/apb3_slave_regbank.md
# apb3_slave_regbank

APB3 completer (slave) implementing a word-addressed register bank with a configurable number of wait states and optional error response. It sits on the slave side of the team's APB3 interface and answers transfers driven by the APB3 master. It provides the PRDATA/PREADY/PSLVERR half of the bus, which the team uses as a bring-up target and bus-functional peer for the master.

## Interface
- `DEPTH`, 16: number of 32-bit registers. Must be a power of two, ≥2.
- `WAIT_STATES`, 1: access-phase cycles with PREADY low before completion. Range 0..15.
- `PCLK` in 1: bus clock; all state updates on its rising edge.
- `PRESETn` in 1: reset, asynchronous, active-low.
- `PSELx` in 1: slave select.
- `PENABLE` in 1: access-phase strobe.
- `PWRITE` in 1: 1 = write, 0 = read.
- `PADDR` in 32: byte address.
- `PWDATA` in 32: write data.
- `PRDATA` out 32: read data. Valid only while PREADY=1 on a read; 0 otherwise.
- `PREADY` out 1: transfer completion.
- `PSLVERR` out 1: error response. Only meaningful while PREADY=1; 0 otherwise.

## Operation
- Register index = PADDR[2 +: log2(DEPTH)]. PADDR, PWRITE and PWDATA are captured in the setup cycle; any changes during the access phase are ignored.
- FSM states:
  - **IDLE**
    - PSELx=1 and PENABLE=0 (setup): capture the request and load the counter with WAIT_STATES.
    - Next state is WAIT if WAIT_STATES>0, otherwise READY.
    - PENABLE=1 without a preceding setup is ignored; the FSM stays in IDLE.
  - **WAIT**
    - PREADY=0. The counter decrements once per cycle.
    - At counter==1, go to READY.
    - PSELx=0 aborts to IDLE with no write.
  - **READY**
    - PREADY=1 (Moore decode of the state flop).
    - PSELx=1 and PENABLE=1: the transfer completes at this edge. A write commits to the register; then go to IDLE.
    - PSELx=0: abort to IDLE with no write.
- Read data:
  - PRDATA is registered.
  - On the transition into READY for a read, it is loaded from the register at the captured index.
  - On leaving READY, it is cleared to 0.
- Reset:
  - PRESETn=0 at any time forces IDLE, counter=0, PREADY=0, PSLVERR=0, PRDATA=0, and all registers to 0.
  - A write in progress during reset is discarded.

## Timing
- Setup cycle S, then access cycles A0..AW, with W = WAIT_STATES.
- PREADY=1 during AW only. The transfer completes at the end of AW.
- Total transfer duration is 2+W cycles.
- A write is visible to a read whose setup cycle follows the completion edge. Back-to-back reads of a just-written register return the new value.
- Back-to-back transfers are supported: a setup in the cycle immediately after AW is accepted (the FSM is in IDLE that cycle).
- PREADY, PSLVERR and PRDATA are all flop outputs; there is no combinational path from inputs.

## Configuration
- `APB3_SLV_ERR_EN` defined:
  - Error condition: the captured PADDR has a word index ≥ DEPTH (PADDR[31:2] ≥ DEPTH) or PADDR[1:0] ≠ 0.
  - On an error, PSLVERR=1 in the READY cycle, the write is suppressed, and PRDATA=0.
  - Wait-state timing is unchanged.
- `APB3_SLV_ERR_EN` undefined:
  - PSLVERR is tied to 0.
  - Upper address bits and PADDR[1:0] are ignored, so the index wraps modulo DEPTH.

## Structure
- Shared package `apb3_pkg`:
  - State enum type `apb3_slv_state_t` with values IDLE, WAIT, READY.
  - Constants `APB3_DATA_W`=32 and `APB3_ADDR_W`=32.
  - Function `apb3_word_idx`.
- Sub-module `apb3_regfile`: DEPTH×32 storage.
  - One synchronous write port and one asynchronous read port.
  - Asynchronous clear on PRESETn.
- The FSM, counter and error decode live in the top level.

## Test plan
- **Reset values:** assert PRESETn=0 mid-access with WAIT_STATES=3 → PREADY, PSLVERR and PRDATA are 0 immediately; a subsequent read of address 0x0 returns 0x0000_0000.
- **Write then read:** with WAIT_STATES=2, write 0xDEAD_BEEF to 0x08, then read 0x08 → PREADY high exactly in the 4th cycle of each transfer; the read returns 0xDEAD_BEEF with PSLVERR=0.
- **Zero wait states:** with WAIT_STATES=0, issue back-to-back writes to 0x0 and 0x4 followed by reads → each transfer takes 2 cycles; reads return the written values.
- **Abort:** drop PSELx in A1 of a write to 0x10 (WAIT_STATES=3) → the FSM returns to IDLE and a later read of 0x10 returns the old value.
- **Errors (`APB3_SLV_ERR_EN`):** write 0x1234 to 0x40 with DEPTH=16, then read 0x02 → PSLVERR=1 with PREADY on both transfers, PRDATA=0, and register 0 is unchanged.
- **Wrap (no macro):** write 0xA5A5_A5A5 to 0x40 with DEPTH=16, then read 0x00 → returns 0xA5A5_A5A5 with PSLVERR=0.
